// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port CPU register file.
//   - NUM_RD combinational read ports (1..4), each with a ready flag
//   - two write ports; wr1 wins when both target the same register
//   - per-register busy scoreboard (reserve sets, committed write clears)
//   - register 0 is hardwired to zero and is never busy
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write
// data (and readiness) onto matching read ports.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_ready,
  input  logic                       wr0_en,
  input  logic [ADDR_W-1:0]          wr0_addr,
  input  logic [DATA_W-1:0]          wr0_data,
  input  logic                       wr1_en,
  input  logic [ADDR_W-1:0]          wr1_addr,
  input  logic [DATA_W-1:0]          wr1_data,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  output logic [(2**ADDR_W)-1:0]     busy_vec
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Register storage. Entry 0 is only ever loaded by reset, so it stays 0.
  logic [DATA_W-1:0] mem_reg [DEPTH];

  // Scoreboard state and its next value.
  logic [DEPTH-1:0]  busy_reg;
  logic [DEPTH-1:0]  busy_next;

  // One-hot address decodes per event; bit 0 is tied low so that register 0
  // can never be written or reserved.
  logic [DEPTH-1:0]  wr0_hit;
  logic [DEPTH-1:0]  wr1_hit;
  logic [DEPTH-1:0]  rsv_hit;

  genvar gi;

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_dec
      if (gi == 0) begin : g_zero
        assign wr0_hit[gi] = 1'b0;
        assign wr1_hit[gi] = 1'b0;
        assign rsv_hit[gi] = 1'b0;
      end else begin : g_nz
        assign wr0_hit[gi] = wr0_en && (wr0_addr == ADDR_W'(gi));
        assign wr1_hit[gi] = wr1_en && (wr1_addr == ADDR_W'(gi));
        assign rsv_hit[gi] = rsv_en && (rsv_addr == ADDR_W'(gi));
      end
    end
  endgenerate

  // Array update: wr1 has priority over wr0 on a shared address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < DEPTH; n++) begin
        mem_reg[n] <= '0;
      end
    end else begin
      for (int n = 1; n < DEPTH; n++) begin
        if (wr1_hit[n]) begin
          mem_reg[n] <= wr1_data;
        end else if (wr0_hit[n]) begin
          mem_reg[n] <= wr0_data;
        end
      end
    end
  end

  // Scoreboard next state: a committed write clears, a reservation sets,
  // and a reservation overrides a clear on the same register (the new
  // producer supersedes the one that just wrote back).
  always_comb begin
    busy_next = busy_reg;
    for (int n = 1; n < DEPTH; n++) begin
      if (wr0_hit[n] || wr1_hit[n]) begin
        busy_next[n] = 1'b0;
      end
      if (rsv_hit[n]) begin
        busy_next[n] = 1'b1;
      end
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy_vec = busy_reg;

  // Read ports: purely combinational from the address to data and ready.
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] array_data;
      logic              array_ready;
      logic              addr_nz;

      assign addr        = rd_addr[gi*ADDR_W +: ADDR_W];
      assign addr_nz     = (addr != '0);
      // mem_reg[0] is already zero; the explicit mux keeps the zero-register
      // behaviour obvious and independent of the storage contents.
      assign array_data  = addr_nz ? mem_reg[addr] : '0;
      assign array_ready = ~busy_reg[addr];

`ifdef REGFILE_BYPASS_EN
      logic wr0_match;
      logic wr1_match;
      logic rsv_match;

      assign wr0_match = wr0_en && (wr0_addr == addr) && addr_nz;
      assign wr1_match = wr1_en && (wr1_addr == addr) && addr_nz;
      assign rsv_match = rsv_en && (rsv_addr == addr) && addr_nz;

      // Forward the winning write; a same-cycle reservation means a newer
      // producer is pending, so the forwarded value is not final.
      assign rd_data[gi*DATA_W +: DATA_W] = wr1_match ? wr1_data :
                                            wr0_match ? wr0_data :
                                            array_data;
      assign rd_ready[gi] = (wr1_match || wr0_match) ? ~rsv_match : array_ready;
`else
      assign rd_data[gi*DATA_W +: DATA_W] = array_data;
      assign rd_ready[gi]                 = array_ready;
`endif
    end
  endgenerate

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file; successor to the single-write, two-read CPU register file.
- Adds:
  - configurable data width, depth and read-port count;
  - two write ports with a fixed priority;
  - a per-register busy scoreboard for hazard tracking;
  - optional write-to-read bypass.
- Sits between decode/issue (reads, reservations) and writeback (writes) in the CPU datapath.

Parameters:
- DATA_W, 32, width of each register in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W entries.
- NUM_RD, 2, number of independent read ports (1..4).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- rd_addr  input  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_data  output  NUM_RD*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W].
- rd_ready  output  NUM_RD  1 = read port i's register is not busy (data final).
- wr0_en  input  1  write port 0 enable.
- wr0_addr  input  ADDR_W  write port 0 address.
- wr0_data  input  DATA_W  write port 0 data.
- wr1_en  input  1  write port 1 enable (priority port).
- wr1_addr  input  ADDR_W  write port 1 address.
- wr1_data  input  DATA_W  write port 1 data.
- rsv_en  input  1  reserve request: mark a register busy (pending producer).
- rsv_addr  input  ADDR_W  register to reserve.
- busy_vec  output  2**ADDR_W  registered scoreboard; bit n = register n busy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers clear to 0;
  - busy_vec clears to 0, hence rd_ready all 1;
  - rd_data reflects the cleared array, i.e. 0.
- Register 0 is hardwired:
  - reads return 0;
  - writes to address 0 are ignored;
  - reservations of address 0 are ignored;
  - busy_vec[0] is constant 0.
- Reads are combinational, with zero latency from rd_addr to rd_data/rd_ready.
- Writes:
  - occur on rising clk when wrN_en=1 and the address is non-zero;
  - the data is visible on the read path the following cycle (or the same cycle with bypass, see Optional Feature).
- Both write ports targeting the same address in the same cycle: wr1 wins; the wr0 data is discarded.
- Scoreboard:
  - on rising clk, rsv_en=1 sets busy[rsv_addr];
  - a committed write on either port clears busy[addr].
- Simultaneous events on the same address:
  - reserve together with a write: reserve wins and busy stays/becomes 1 (the new producer supersedes); the write data is still stored.
  - clear from wr0 and wr1 on different addresses: both clear.
- rd_ready[i] = ~busy[rd_addr_i]. rd_addr_i = 0 always gives rd_ready 1.
- Write to a non-busy register: allowed; stores the data; busy is unchanged (0).
- Reset asserted mid-cycle:
  - the array and scoreboard clear immediately;
  - writes/reserves in that cycle are lost;
  - the first edge after rst_n rises behaves normally.
- No other state; no X on any output after reset.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - any read port whose address matches an enabled, non-zero write address in the same cycle returns that write's data combinationally (wr1 has priority if both match);
  - rd_ready for that port is also forced 1 unless rsv_en targets the same address that cycle.
- Undefined:
  - same-cycle reads return the pre-write value and current busy state;
  - the new value appears the next cycle.

Test Plan:
- Reset then read all ports at addrs 0, 7, 31 -> rd_data 0, rd_ready 1, busy_vec 0.
- wr0 addr 5 data 0xDEADBEEF; next cycle read addr 5 -> 0xDEADBEEF; write addr 0 data 0x1234 -> read addr 0 returns 0.
- Same cycle: wr0 addr 9 data 0x11 and wr1 addr 9 data 0x22; next cycle read 9 -> 0x22.
- rsv addr 3 -> busy_vec[3]=1 and rd_ready 0 on a port reading 3; wr1 addr 3 data 0x55 -> next cycle busy_vec[3]=0, rd_ready 1, data 0x55; rsv+wr addr 3 same cycle -> busy stays 1, data stored.
- With REGFILE_BYPASS_EN: wr0 addr 12 data 0xA5A5 and read addr 12 same cycle -> rd_data 0xA5A5. Without the macro -> old value 0 that cycle, 0xA5A5 the next.
- Busy regs 4 and 6 with data written to both, then assert rst_n=0 mid-cycle -> busy_vec 0 and reads 0 immediately, without waiting for a clock edge.
